// File: rtl/bit_collector_pkg.sv
// Shared encodings and frame sizing for the bit_collector serial-to-parallel block.
package bit_collector_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } coll_state_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // Strobes per frame beyond the WIDTH data bits.
  localparam int FRAME_EXTRA_PLAIN  = 0;
  localparam int FRAME_EXTRA_PARITY = 1;

  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int frame_len(input int width, input bit parity_en);
    return width + (parity_en ? FRAME_EXTRA_PARITY : FRAME_EXTRA_PLAIN);
  endfunction

endpackage

// File: rtl/bit_collector_hold.sv
// Output holding register: valid/ready handshake, drop detection and sticky overrun.
module bit_collector_hold
  import bit_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             perr_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] word_o,
  output logic             valid_o,
  output logic             overrun_o,
  output logic             parity_err_o
);

  out_state_t       state_q;
  logic [WIDTH-1:0] word_q;
  logic             overrun_q;
  logic             perr_q;
  logic             xfer_d;

  assign xfer_d = (state_q == FULL) && ready_i;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= EMPTY;
      word_q    <= '0;
      overrun_q <= 1'b0;
      perr_q    <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (load_i) begin
            word_q  <= data_i;
            perr_q  <= perr_i;
            state_q <= FULL;
          end
        end
        FULL: begin
          // A completion coinciding with a transfer replaces the word in place.
          if (load_i && xfer_d) begin
            word_q <= data_i;
            perr_q <= perr_i;
          end else if (load_i) begin
            overrun_q <= 1'b1;
          end else if (xfer_d) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign word_o       = word_q;
  assign valid_o      = (state_q == FULL);
  assign overrun_o    = overrun_q;
  assign parity_err_o = perr_q;

endmodule

// File: rtl/bit_collector.sv
// Serial-to-parallel collector behind an enabled D register; LSB-first packing.
// Optional even-parity frame bit enabled with `define BIT_COLLECTOR_PARITY_EN.
module bit_collector
  import bit_collector_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          D,
  input  logic                          en,
  input  logic                          ready,
  output logic [WIDTH-1:0]              word,
  output logic                          valid,
  output logic                          overrun,
  output logic                          parity_err,
  output logic [count_width(WIDTH)-1:0] bit_count
);

`ifdef BIT_COLLECTOR_PARITY_EN
  localparam int N = frame_len(WIDTH, 1'b1);
`else
  localparam int N = frame_len(WIDTH, 1'b0);
`endif
  localparam int CW   = count_width(WIDTH);
  // Only the bits that precede the completing strobe need storage.
  localparam int SR_W = N - 1;

  coll_state_t      state_q;
  logic [CW-1:0]    cnt_q;
  logic [SR_W-1:0]  shreg_q;

  logic             last_bit_d;
  logic [SR_W-1:0]  shreg_d;
  logic [WIDTH-1:0] load_word_d;
  logic             load_perr_d;

  always_comb begin
    last_bit_d = en && (state_q == SHIFT) && (cnt_q == CW'(N - 1));
    shreg_d    = SR_W'({D, shreg_q} >> 1);
`ifdef BIT_COLLECTOR_PARITY_EN
    load_word_d = shreg_q;
    load_perr_d = (^shreg_q) ^ D;
`else
    load_word_d = {D, shreg_q};
    load_perr_d = 1'b0;
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
    end else if (en) begin
      case (state_q)
        IDLE: begin
          state_q <= SHIFT;
          cnt_q   <= CW'(1);
          shreg_q <= shreg_d;
        end
        SHIFT: begin
          if (last_bit_d) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            shreg_q <= shreg_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bit_collector_hold #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clock       (clock),
    .reset       (reset),
    .load_i      (last_bit_d),
    .data_i      (load_word_d),
    .perr_i      (load_perr_d),
    .ready_i     (ready),
    .word_o      (word),
    .valid_o     (valid),
    .overrun_o   (overrun),
    .parity_err_o(parity_err)
  );

  assign bit_count = cnt_q;

endmodule

// File: tb/tb_bit_collector.sv
// Directed bench for bit_collector (WIDTH=8); parity cases run when BIT_COLLECTOR_PARITY_EN is defined.
module tb_bit_collector;

  localparam int WIDTH = 8;
`ifdef BIT_COLLECTOR_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             D     = 1'b0;
  logic             en    = 1'b0;
  logic             ready = 1'b0;
  logic [WIDTH-1:0] word;
  logic             valid;
  logic             overrun;
  logic             parity_err;
  logic [3:0]       bit_count;

  int tests = 0;
  int fails = 0;

  bit_collector #(.WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .D         (D),
    .en        (en),
    .ready     (ready),
    .word      (word),
    .valid     (valid),
    .overrun   (overrun),
    .parity_err(parity_err),
    .bit_count (bit_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame as sent on the wire: data LSB-first, then the even-parity bit if enabled.
  function automatic logic [31:0] frame(input logic [7:0] w);
`ifdef BIT_COLLECTOR_PARITY_EN
    return {23'd0, ^w, w};
`else
    return {24'd0, w};
`endif
  endfunction

  task automatic send_bits(input logic [31:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      D  = f[i];
      en = 1'b1;
      @(posedge clock); #1;
    end
    en = 1'b0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] f;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    chk("rst_word", word, 0);
    chk("rst_valid", valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_count", bit_count, 0);

    // Continuous strobes, consumer always ready.
    ready = 1'b1;
    f = frame(8'hA5);
    send_bits(f, NB - 1);
    chk("cont_count_pre", bit_count, NB - 1);
    chk("cont_valid_pre", valid, 0);
    send_bits(f >> (NB - 1), 1);
    chk("cont_valid", valid, 1);
    chk("cont_word", word, 32'hA5);
    chk("cont_overrun", overrun, 0);
    chk("cont_count_done", bit_count, 0);
    tick();
    chk("cont_valid_1cyc", valid, 0);
    chk("cont_word_hold", word, 32'hA5);

    // Strobe every other cycle; count moves only on strobe edges.
    for (int i = 0; i < NB; i++) begin
      D  = f[i];
      en = 1'b1;
      tick();
      en = 1'b0;
      chk("tog_cnt_strobe", bit_count, (i + 1) % NB);
      chk("tog_valid", valid, (i == NB - 1) ? 1 : 0);
      tick();
      chk("tog_cnt_gap", bit_count, (i + 1) % NB);
    end
    chk("tog_word", word, 32'hA5);
    chk("tog_valid_drop", valid, 0);

    // Consumer stalled: second word is dropped.
    ready = 1'b0;
    send_bits(frame(8'h3C), NB);
    chk("ovr_word1", word, 32'h3C);
    chk("ovr_ovr1", overrun, 0);
    send_bits(frame(8'hFF), NB);
    chk("ovr_word2", word, 32'h3C);
    chk("ovr_valid2", valid, 1);
    chk("ovr_set", overrun, 1);
    ready = 1'b1;
    tick();
    chk("ovr_xfer_valid", valid, 0);
    chk("ovr_xfer_word", word, 32'h3C);
    chk("ovr_sticky", overrun, 1);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Transfer and completion on the same edge.
    ready = 1'b0;
    send_bits(frame(8'h3C), NB);
    f = frame(8'hFF);
    send_bits(f, NB - 1);
    chk("same_word_pre", word, 32'h3C);
    ready = 1'b1;
    send_bits(f >> (NB - 1), 1);
    chk("same_valid", valid, 1);
    chk("same_word", word, 32'hFF);
    chk("same_overrun", overrun, 0);
    tick();
    chk("same_drain", valid, 0);

    // Reset mid-word, with a strobe present on the reset edge.
    send_bits(frame(8'hFF), 5);
    chk("mid_count5", bit_count, 5);
    reset = 1'b1;
    en    = 1'b1;
    D     = 1'b1;
    tick();
    reset = 1'b0;
    en    = 1'b0;
    chk("mid_count_rst", bit_count, 0);
    chk("mid_valid_rst", valid, 0);
    send_bits(frame(8'h81), NB);
    chk("mid_word", word, 32'h81);
    chk("mid_valid", valid, 1);
    tick();

`ifdef BIT_COLLECTOR_PARITY_EN
    send_bits({23'd0, 1'b1, 8'h07}, NB);
    chk("par_ok_word", word, 32'h07);
    chk("par_ok", parity_err, 0);
    tick();
    send_bits({23'd0, 1'b0, 8'h07}, NB);
    chk("par_bad_word", word, 32'h07);
    chk("par_bad", parity_err, 1);
    tick();
`else
    chk("par_tied", parity_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish by 200000");
    $fatal(1, "timeout");
  end

endmodule
